// File: rtl/cl_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial logic-cell sequencer:
// op codes, FSM state encoding and the 4:1 select used by the cell.
package cl_serial_ctrl_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic mux4_1(input logic [3:0] d, input logic [1:0] sel);
    return d[sel];
  endfunction

endpackage

// File: rtl/cl_serial_ctrl_cl.sv
// 1-bit logic cell: computes AND/OR/XOR of a,b or NOT a, chosen by op.
module cl_serial_ctrl_cl
  import cl_serial_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  logic [3:0] cand;

  // Candidate order matches the op-code values so op indexes directly.
  assign cand = {~a, a ^ b, a | b, a & b};
  assign y    = mux4_1(cand, op);

endmodule

// File: rtl/cl_serial_ctrl.sv
// Streams two WIDTH-bit operands LSB-first through one logic cell and
// assembles the result; done pulses for one cycle when result updates.
module cl_serial_ctrl
  import cl_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt;
  logic             cl_y;
  logic [WIDTH-1:0] acc_next;

  cl_serial_ctrl_cl u_cl (
    .a  (sh_a[0]),
    .b  (sh_b[0]),
    .op (op_r),
    .y  (cl_y)
  );

  // New cell output enters at the MSB so bit 0 ends up in result[0].
  assign acc_next = {cl_y, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      acc    <= '0;
      op_r   <= OP_AND;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            op_r  <= op;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc  <= acc_next;
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          if (cnt == CNT_LAST) begin
            result <= acc_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cl_serial_ctrl.sv
// Self-checking bench for cl_serial_ctrl: directed cases plus random ops
// compared against a word-level bitwise reference.
module tb_cl_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model_result;

  cl_serial_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One operation; inj_cycle >= 0 pulses a bogus start in that RUN cycle,
  // scramble changes the operand inputs right after acceptance.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input int inj_cycle, input bit scramble);
    logic [W-1:0] expv;
    logic [31:0]  rnd;
    expv = ref_op(o, ia, ib);
    @(negedge clk);
    op = o; a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check_eq("run_busy", busy, 1'b1);
      check_eq("run_done", done, 1'b0);
      check_eq("run_result_held", result, model_result);
      start = (i == inj_cycle);
      if (i == inj_cycle) begin
        a = '0; b = '0; op = 2'b01;
      end
      if (scramble && i == 0) begin
        rnd = $urandom; a = rnd[W-1:0];
        rnd = $urandom; b = rnd[W-1:0];
        op = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("done_pulse", done, 1'b1);
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_result", result, expv);
    model_result = expv;
    @(negedge clk);
    check_eq("after_done", done, 1'b0);
    check_eq("after_busy", busy, 1'b0);
    check_eq("after_result", result, expv);
    $display("op=%0d a=%h b=%h result=%h expected=%h", o, ia, ib, result, expv);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [W-1:0] ra, rb;
    int ndone, last;

    // Reset with random inputs, including start.
    reset_n = 1'b0;
    start = 1'($urandom_range(0, 1));
    rnd = $urandom; a = rnd[W-1:0];
    rnd = $urandom; b = rnd[W-1:0];
    op = 2'($urandom_range(0, 3));
    model_result = '0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_result", result, '0);
    end
    start = 1'b0;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_done", done, 1'b0);
      check_eq("idle_result", result, '0);
    end

    // Directed ops.
    do_op(2'b00, 8'hF0, 8'h3C, -1, 1'b0);
    do_op(2'b01, 8'hA5, 8'h5A, -1, 1'b0);
    do_op(2'b10, 8'hFF, 8'h0F, -1, 1'b0);
    do_op(2'b11, 8'h96, 8'hFF, -1, 1'b0);

    // Start during RUN is ignored.
    do_op(2'b00, 8'hF0, 8'h3C, 3, 1'b0);

    // Asynchronous reset in RUN cycle 4.
    @(negedge clk);
    op = 2'b00; a = 8'hF0; b = 8'h3C; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_result", result, '0);
    model_result = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (W + 3) begin
      @(negedge clk);
      check_eq("postrst_done", done, 1'b0);
      check_eq("postrst_busy", busy, 1'b0);
    end
    do_op(2'b10, 8'hFF, 8'h0F, -1, 1'b0);

    // Random ops with operand changes after acceptance.
    for (int n = 0; n < 16; n++) begin
      rnd = $urandom; ra = rnd[W-1:0];
      rnd = $urandom; rb = rnd[W-1:0];
      do_op(2'($urandom_range(0, 3)), ra, rb, -1, 1'b1);
    end

    // Back-to-back with start held high.
    rnd = $urandom; ra = rnd[W-1:0];
    rnd = $urandom; rb = rnd[W-1:0];
    @(negedge clk);
    op = 2'b10; a = ra; b = rb; start = 1'b1;
    ndone = 0;
    last = -1;
    for (int j = 1; j <= 3 * (W + 2) - 1; j++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check_eq("b2b_result", result, ra ^ rb);
        if (last >= 0) check_eq("b2b_spacing", j - last, W + 2);
        else           check_eq("b2b_first", j, W + 1);
        last = j;
      end
    end
    start = 1'b0;
    check_eq("b2b_count", ndone, 3);
    $display("back-to-back xor a=%h b=%h pulses=%0d result=%h", ra, rb, ndone, result);
    @(negedge clk);
    check_eq("b2b_idle_busy", busy, 1'b0);
    check_eq("b2b_idle_done", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
